// File: rtl/fpu_issue_arbiter_32.sv
// Round-robin issue arbiter sharing one FPU among NUM_REQ requesters, with a tagged, credit-protected response FIFO.
// Define FPU_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins); the default build is round-robin.
module fpu_issue_arbiter_32 #(
  parameter int BIT_WIDTH   = 32,
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 1,
  parameter int RSP_DEPTH   = 4,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [3*NUM_REQ-1:0]         i_req_mode,
  input  logic [2*NUM_REQ-1:0]         i_req_operation,
  input  logic [BIT_WIDTH*NUM_REQ-1:0] i_req_inputA,
  input  logic [BIT_WIDTH*NUM_REQ-1:0] i_req_inputB,
  output logic                         o_fpu_valid,
  output logic [2:0]                   o_fpu_mode,
  output logic [1:0]                   o_fpu_operation,
  output logic [BIT_WIDTH-1:0]         o_fpu_inputA,
  output logic [BIT_WIDTH-1:0]         o_fpu_inputB,
  input  logic [BIT_WIDTH-1:0]         i_fpu_output,
  input  logic [4:0]                   i_fpu_exeption,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [ID_W-1:0]              o_rsp_id,
  output logic [BIT_WIDTH-1:0]         o_rsp_output,
  output logic [4:0]                   o_rsp_exeption
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = $clog2(RSP_DEPTH);

  logic [2:0]           req_mode [NUM_REQ];
  logic [1:0]           req_op   [NUM_REQ];
  logic [BIT_WIDTH-1:0] req_a    [NUM_REQ];
  logic [BIT_WIDTH-1:0] req_b    [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_mode[r] = i_req_mode[3*r +: 3];
    assign req_op[r]   = i_req_operation[2*r +: 2];
    assign req_a[r]    = i_req_inputA[BIT_WIDTH*r +: BIT_WIDTH];
    assign req_b[r]    = i_req_inputB[BIT_WIDTH*r +: BIT_WIDTH];
  end

  logic [ID_W-1:0]      ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 found;
  logic [ID_W-1:0]      idx;
  logic                 accept;
  logic                 pop;
  logic                 credit_ok;
  logic [ID_W-1:0]      iss_id;
  logic [FPU_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]      tag_id [FPU_LATENCY];
  logic [ID_W-1:0]      mem_id  [RSP_DEPTH];
  logic [BIT_WIDTH-1:0] mem_out [RSP_DEPTH];
  logic [4:0]           mem_exc [RSP_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fcnt;
  logic                 wr_en;

  assign pop   = o_rsp_valid & i_rsp_ready;
  assign wr_en = tag_v[FPU_LATENCY-1];
  // A pop this cycle frees a slot, so a full credit count may still accept.
  assign credit_ok = (cnt < CW'(RSP_DEPTH)) || pop;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    if (rst || !credit_ok) grant = '0;
  end

  assign o_req_ready = grant;
  assign accept      = |grant;

  assign o_rsp_valid    = (fcnt != '0);
  assign o_rsp_id       = o_rsp_valid ? mem_id[rd_ptr]  : '0;
  assign o_rsp_output   = o_rsp_valid ? mem_out[rd_ptr] : '0;
  assign o_rsp_exeption = o_rsp_valid ? mem_exc[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      cnt             <= '0;
      o_fpu_valid     <= 1'b0;
      o_fpu_mode      <= '0;
      o_fpu_operation <= '0;
      o_fpu_inputA    <= '0;
      o_fpu_inputB    <= '0;
      iss_id          <= '0;
      tag_v           <= '0;
      for (int s = 0; s < FPU_LATENCY; s++) tag_id[s] <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fcnt            <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
`ifdef FPU_ARB_FIXED_PRIO_EN
      ptr <= '0;
`else
      if (accept) ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif
      o_fpu_valid <= accept;
      if (accept) begin
        o_fpu_mode      <= req_mode[grant_id];
        o_fpu_operation <= req_op[grant_id];
        o_fpu_inputA    <= req_a[grant_id];
        o_fpu_inputB    <= req_b[grant_id];
        iss_id          <= grant_id;
      end
      tag_v[0]  <= o_fpu_valid;
      tag_id[0] <= iss_id;
      for (int s = 1; s < FPU_LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible between write and pop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_id[wr_ptr]  <= tag_id[FPU_LATENCY-1];
      mem_out[wr_ptr] <= i_fpu_output;
      mem_exc[wr_ptr] <= i_fpu_exeption;
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter_32.sv
// Scoreboard bench for fpu_issue_arbiter_32: directed requests, a behavioural FPU with one-cycle latency, and a response monitor.
module tb_fpu_issue_arbiter_32;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   i_req_valid = '0;
  logic [3:0]   o_req_ready;
  logic [11:0]  i_req_mode = '0;
  logic [7:0]   i_req_operation = '0;
  logic [127:0] i_req_inputA = '0;
  logic [127:0] i_req_inputB = '0;
  logic         o_fpu_valid;
  logic [2:0]   o_fpu_mode;
  logic [1:0]   o_fpu_operation;
  logic [31:0]  o_fpu_inputA, o_fpu_inputB;
  logic [31:0]  fpu_out = '0;
  logic [4:0]   fpu_exc = '0;
  logic         o_rsp_valid;
  logic         i_rsp_ready = 1'b1;
  logic [1:0]   o_rsp_id;
  logic [31:0]  o_rsp_output;
  logic [4:0]   o_rsp_exeption;

  int checks = 0;
  int failures = 0;
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;

  always #5 clk = ~clk;

  fpu_issue_arbiter_32 dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_mode(i_req_mode), .i_req_operation(i_req_operation),
    .i_req_inputA(i_req_inputA), .i_req_inputB(i_req_inputB),
    .o_fpu_valid(o_fpu_valid), .o_fpu_mode(o_fpu_mode), .o_fpu_operation(o_fpu_operation),
    .o_fpu_inputA(o_fpu_inputA), .o_fpu_inputB(o_fpu_inputB),
    .i_fpu_output(fpu_out), .i_fpu_exeption(fpu_exc),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_output(o_rsp_output), .o_rsp_exeption(o_rsp_exeption)
  );

  // Stand-in FPU: exact results for the directed float vectors, a cheap tagged pattern otherwise.
  function automatic logic [36:0] fpu_fn(input logic [1:0] op, input logic [2:0] mode,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
    if (op == 2'b11 && b == 32'h00000000 && a != 32'h0) return {32'h7F800000, 5'b00100};
    return {a ^ {b[15:0], b[31:16]} ^ {27'b0, mode, op}, mode, op};
  endfunction

  always @(posedge clk)
    if (o_fpu_valid) {fpu_out, fpu_exc} <= fpu_fn(o_fpu_operation, o_fpu_mode, o_fpu_inputA, o_fpu_inputB);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual id=%0d out=%h required=no response", o_rsp_id, o_rsp_output);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 64'(o_rsp_id), 64'(mon_e[38:37]));
        chk("rsp_output", 64'(o_rsp_output), 64'(mon_e[36:5]));
        chk("rsp_exeption", 64'(o_rsp_exeption), 64'(mon_e[4:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [1:0] op, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] b);
    i_req_valid[r]          = v;
    i_req_operation[2*r+:2] = op;
    i_req_mode[3*r+:3]      = m;
    i_req_inputA[32*r+:32]  = a;
    i_req_inputB[32*r+:32]  = b;
  endtask

  // Called at a negedge: g is the requester this cycle must grant (-1 for none).
  task automatic expect_grant(input int g);
    logic [3:0] oh;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    chk($sformatf("req_ready_g%0d", g), 64'(o_req_ready), 64'(oh));
    if (g >= 0)
      exp_q.push_back({2'(g), fpu_fn(i_req_operation[2*g+:2], i_req_mode[3*g+:3],
                                     i_req_inputA[32*g+:32], i_req_inputB[32*g+:32])});
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({o_req_ready, o_fpu_valid, o_fpu_mode, o_fpu_operation,
                           o_rsp_valid, o_rsp_id, o_rsp_exeption}), 64'(0));
    chk({tag, "_fpu_ab"}, {o_fpu_inputA, o_fpu_inputB}, 64'(0));
    chk({tag, "_rsp_out"}, 64'(o_rsp_output), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests pending: ready must stay low.
    i_req_valid = 4'b1111;
    #12;
    chk_all_zero("reset");
    cyc();
    rst = 1'b0;
    for (int r = 0; r < 4; r++)
      set_req(r, 1'b1, 2'(r), 3'(r), 32'h41000000 + 32'(r), 32'h00001000 * 32'(r + 1));

    // Contention from ptr=0.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef FPU_ARB_FIXED_PRIO_EN
      expect_grant(0);
`else
      expect_grant(k % 4);
`endif
      cyc();
    end
    i_req_valid = '0;
    drain(20);

    // Single request from requester 2, latency check.
    set_req(2, 1'b1, 2'b00, 3'd0, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    expect_grant(2);
    cyc();
    i_req_valid[2] = 1'b0;
    @(negedge clk);
    chk("single_fpu_valid_c1", 64'(o_fpu_valid), 64'(1));
    chk("single_fpu_ops_c1", {o_fpu_inputA, o_fpu_inputB}, 64'h3F800000_40000000);
    chk("single_fpu_op_c1", 64'(o_fpu_operation), 64'(0));
    chk("single_rsp_valid_c1", 64'(o_rsp_valid), 64'(0));
    cyc();
    @(negedge clk);
    chk("single_fpu_valid_c2", 64'(o_fpu_valid), 64'(0));
    chk("single_rsp_valid_c2", 64'(o_rsp_valid), 64'(0));
    cyc();
    @(negedge clk);
    chk("single_rsp_valid_c3", 64'(o_rsp_valid), 64'(1));
    drain(10);

    // Divide by zero from requester 3.
    set_req(3, 1'b1, 2'b11, 3'd0, 32'h3F800000, 32'h00000000);
    @(negedge clk);
    expect_grant(3);
    cyc();
    i_req_valid[3] = 1'b0;
    drain(10);

    // Backpressure: requester 1 streams MULs into a stalled consumer.
    i_rsp_ready = 1'b0;
    set_req(1, 1'b1, 2'b10, 3'd1, 32'h40000000, 32'h3FC00000);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      expect_grant(1);
      cyc();
      set_req(1, 1'b1, 2'b10, 3'd1, 32'h40000000, 32'h3FC00000 + 32'(n + 1));
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      expect_grant(-1);
      chk("bp_rsp_valid", 64'(o_rsp_valid), 64'(1));
      cyc();
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    expect_grant(1);
    cyc();
    i_req_valid[1] = 1'b0;
    drain(20);

    // Mid-operation reset: one queued, one at the FPU, one in the issue stage.
    i_rsp_ready = 1'b0;
    set_req(2, 1'b1, 2'b01, 3'd2, 32'h42000000, 32'h41000000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_grant(2);
      cyc();
      set_req(2, 1'b1, 2'b01, 3'd2, 32'h42000000 + 32'(k + 1), 32'h41000000);
    end
    i_req_valid[2] = 1'b0;
    set_req(0, 1'b1, 2'b00, 3'd3, 32'h12345678, 32'h9ABCDEF0);
    set_req(3, 1'b1, 2'b10, 3'd4, 32'h0F0F0F0F, 32'hF0F0F0F0);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    expect_grant(0);
    cyc();
    i_req_valid[0] = 1'b0;
    @(negedge clk);
    expect_grant(3);
    cyc();
    i_req_valid[3] = 1'b0;
    repeat (8) @(posedge clk);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
